// File: rtl/sync_window_counter.sv
// sync_window_counter: derives active-window X/Y coordinates, frame start/done
// pulses and framing error flags from the pipeline-aligned OV7620 HSYNC/VSYNC pair.
module sync_window_counter #(
  parameter int unsigned H_BACK   = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_BACK   = 1,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        HSYNC,
  input  logic        VSYNC,
  output logic [10:0] X,
  output logic [9:0]  Y,
  output logic        ACTIVE,
  output logic        FRAME_START,
  output logic        FRAME_DONE,
  output logic        LINE_ERR,
  output logic        FRAME_ERR,
  output logic [7:0]  FRAME_CNT
);

  typedef enum logic [1:0] {
    WAIT_V = 2'd0,
    BLANK  = 2'd1,
    LINES  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [11:0] H_FIRST = 12'(H_BACK);
  localparam logic [11:0] H_LAST  = 12'(H_BACK + H_ACTIVE - 1);
  localparam logic [10:0] V_FIRST = 11'(V_BACK + 1);
  localparam logic [10:0] V_LAST  = 11'(V_BACK + V_ACTIVE);

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hedge, vedge;
  logic [11:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  state_e      state_q, state_d;
  logic        inwin, last_pix;

  logic        active_q, active_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  // Sync pulses are active-low, so the rising edge marks the end of the pulse.
  always_comb begin
    hsync_d = HSYNC;
    vsync_d = VSYNC;
    hedge   = HSYNC & ~hsync_q;
    vedge   = VSYNC & ~vsync_q;
  end

  always_comb begin
    hcnt_d = hcnt_q;
    if (hedge || vedge) begin
      hcnt_d = '0;
    end else if (hcnt_q != '1) begin
      hcnt_d = hcnt_q + 12'd1;
    end

    vcnt_d = vcnt_q;
    if (vedge) begin
      vcnt_d = '0;
    end else if (hedge && (vcnt_q != '1)) begin
      vcnt_d = vcnt_q + 11'd1;
    end
  end

  always_comb begin
    inwin = (state_q == LINES) &&
            (hcnt_q >= H_FIRST) && (hcnt_q <= H_LAST) &&
            (vcnt_q >= V_FIRST) && (vcnt_q <= V_LAST);
    last_pix = inwin && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= WAIT_V;
    end else begin
      state_q <= state_d;
    end
  end

  // A VSYNC rising edge restarts the frame from any state; a coincident HSYNC edge is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_V: begin
        if (vedge) state_d = BLANK;
      end
      BLANK: begin
        if (vedge) begin
          state_d = BLANK;
        end else if (hedge && (vcnt_d == V_FIRST)) begin
          state_d = LINES;
        end
      end
      LINES: begin
        if (vedge) begin
          state_d = BLANK;
        end else if (last_pix) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (vedge) state_d = BLANK;
      end
      default: state_d = WAIT_V;
    endcase
  end

  always_comb begin
    active_d      = inwin;
    x_d           = '0;
    y_d           = '0;
    frame_start_d = 1'b0;
    frame_done_d  = last_pix;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (inwin) begin
      x_d           = 11'(hcnt_q - H_FIRST);
      y_d           = 10'(vcnt_q - V_FIRST);
      frame_start_d = (hcnt_q == H_FIRST) && (vcnt_q == V_FIRST);
    end

    // A line ended before its last pixel; the window simply continues with the next line.
    if ((state_q == LINES) && hedge && !vedge && (hcnt_q < H_LAST)) begin
      line_err_d = 1'b1;
    end

    if ((state_q == LINES) && vedge && !last_pix) begin
      frame_err_d = 1'b1;
    end

    if (last_pix) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign X           = x_q;
  assign Y           = y_q;
  assign ACTIVE      = active_q;
  assign FRAME_START = frame_start_q;
  assign FRAME_DONE  = frame_done_q;
  assign LINE_ERR    = line_err_q;
  assign FRAME_ERR   = frame_err_q;
  assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_sync_window_counter.sv
// tb_sync_window_counter: directed frames on a shrunken 4x3 window, tallying the
// outputs each cycle and comparing the tallies to hand-computed values.
module tb_sync_window_counter;

  localparam int HB = 2;
  localparam int HA = 4;
  localparam int VB = 1;
  localparam int VA = 3;

  logic        CLK   = 1'b0;
  logic        RSTn  = 1'b1;
  logic        HSYNC = 1'b1;
  logic        VSYNC = 1'b1;
  logic [10:0] X;
  logic [9:0]  Y;
  logic        ACTIVE;
  logic        FRAME_START;
  logic        FRAME_DONE;
  logic        LINE_ERR;
  logic        FRAME_ERR;
  logic [7:0]  FRAME_CNT;

  int compared   = 0;
  int mismatched = 0;

  int          act_count, start_count, done_count, line_err_count, frame_err_count;
  int          zero_viol, cnt_step_bad, wrap_seen;
  logic [20:0] start_xy, done_xy;
  logic [7:0]  prev_cnt;
  logic [20:0] pix_q[$];
  logic [20:0] exp_q[$];

  sync_window_counter #(
    .H_BACK  (HB),
    .H_ACTIVE(HA),
    .V_BACK  (VB),
    .V_ACTIVE(VA)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .HSYNC      (HSYNC),
    .VSYNC      (VSYNC),
    .X          (X),
    .Y          (Y),
    .ACTIVE     (ACTIVE),
    .FRAME_START(FRAME_START),
    .FRAME_DONE (FRAME_DONE),
    .LINE_ERR   (LINE_ERR),
    .FRAME_ERR  (FRAME_ERR),
    .FRAME_CNT  (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearTallies();
    act_count       = 0;
    start_count     = 0;
    done_count      = 0;
    line_err_count  = 0;
    frame_err_count = 0;
    zero_viol       = 0;
    cnt_step_bad    = 0;
    wrap_seen       = 0;
    start_xy        = '1;
    done_xy         = '1;
    pix_q.delete();
    exp_q.delete();
  endtask

  // Drive one cycle of sync inputs, then tally the registered outputs 1 time unit after the edge.
  task automatic applyStimulus(input logic h, input logic v);
    logic [7:0] nxt;
    HSYNC = h;
    VSYNC = v;
    @(posedge CLK);
    #1;
    if (ACTIVE) begin
      act_count++;
      pix_q.push_back({Y, X});
    end else if ((X != 11'd0) || (Y != 10'd0) || FRAME_START || FRAME_DONE) begin
      zero_viol++;
    end
    if (FRAME_START) begin
      start_count++;
      start_xy = {Y, X};
    end
    if (FRAME_DONE) begin
      done_count++;
      done_xy = {Y, X};
    end
    if (LINE_ERR)  line_err_count++;
    if (FRAME_ERR) frame_err_count++;
    nxt = prev_cnt + 8'd1;
    if (FRAME_CNT !== prev_cnt) begin
      if ((prev_cnt == 8'd255) && (FRAME_CNT == 8'd0)) wrap_seen++;
      if ((FRAME_CNT !== nxt) || !FRAME_DONE) cnt_step_bad++;
      prev_cnt = FRAME_CNT;
    end else if (FRAME_DONE) begin
      cnt_step_bad++;
    end
  endtask

  task automatic sendLine(input int n_high);
    repeat (2) applyStimulus(1'b0, 1'b1);
    repeat (n_high) applyStimulus(1'b1, 1'b1);
  endtask

  task automatic sendVsync();
    repeat (2) applyStimulus(1'b1, 1'b0);
  endtask

  task automatic nominalFrame();
    sendVsync();
    repeat (4) sendLine(8);
  endtask

  task automatic expectLine(input int y, input int nx);
    for (int x = 0; x < nx; x++) exp_q.push_back({10'(y), 11'(x)});
  endtask

  task automatic checkPixels(input string tag);
    checkOutput({tag, "_count"}, 32'(pix_q.size()), 32'(exp_q.size()));
    for (int i = 0; (i < exp_q.size()) && (i < pix_q.size()); i++) begin
      checkOutput($sformatf("%s_pix%0d", tag, i), 32'(pix_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_active"},      32'(ACTIVE),      32'd0);
    checkOutput({tag, "_x"},           32'(X),           32'd0);
    checkOutput({tag, "_y"},           32'(Y),           32'd0);
    checkOutput({tag, "_frame_start"}, 32'(FRAME_START), 32'd0);
    checkOutput({tag, "_frame_done"},  32'(FRAME_DONE),  32'd0);
    checkOutput({tag, "_line_err"},    32'(LINE_ERR),    32'd0);
    checkOutput({tag, "_frame_err"},   32'(FRAME_ERR),   32'd0);
    checkOutput({tag, "_frame_cnt"},   32'(FRAME_CNT),   32'd0);
  endtask

  task automatic doReset();
    HSYNC = 1'b1;
    VSYNC = 1'b1;
    RSTn  = 1'b0;
    #1;
    checkAllZero("reset");
    @(posedge CLK);
    #3;
    RSTn     = 1'b1;
    prev_cnt = 8'd0;
  endtask

  task automatic checkNominal(input string tag, input int exp_cnt);
    expectLine(0, 4);
    expectLine(1, 4);
    expectLine(2, 4);
    checkPixels(tag);
    checkOutput({tag, "_starts"},    32'(start_count),     32'd1);
    checkOutput({tag, "_start_xy"},  32'(start_xy),        32'd0);
    checkOutput({tag, "_dones"},     32'(done_count),      32'd1);
    checkOutput({tag, "_done_xy"},   32'(done_xy),         32'({10'd2, 11'd3}));
    checkOutput({tag, "_line_errs"}, 32'(line_err_count),  32'd0);
    checkOutput({tag, "_frame_errs"},32'(frame_err_count), 32'd0);
    checkOutput({tag, "_zero_viol"}, 32'(zero_viol),       32'd0);
    checkOutput({tag, "_cnt_step"},  32'(cnt_step_bad),    32'd0);
    checkOutput({tag, "_frame_cnt"}, 32'(FRAME_CNT),       32'(exp_cnt));
  endtask

  initial begin
    prev_cnt = 8'd0;
    clearTallies();
    #2;
    doReset();

    $display("[TB] HSYNC only, no VSYNC edge");
    clearTallies();
    repeat (6) sendLine(8);
    checkOutput("novs_active", 32'(act_count), 32'd0);
    checkOutput("novs_starts", 32'(start_count), 32'd0);
    checkOutput("novs_errs",   32'(line_err_count + frame_err_count), 32'd0);
    checkOutput("novs_zero",   32'(zero_viol), 32'd0);

    $display("[TB] nominal frame");
    clearTallies();
    nominalFrame();
    checkNominal("nom", 1);

    $display("[TB] short line at Y=1");
    clearTallies();
    sendVsync();
    sendLine(8);
    sendLine(8);
    sendLine(3);
    sendLine(8);
    expectLine(0, 4);
    expectLine(1, 3);
    expectLine(2, 4);
    checkPixels("short");
    checkOutput("short_line_errs",  32'(line_err_count),  32'd1);
    checkOutput("short_frame_errs", 32'(frame_err_count), 32'd0);
    checkOutput("short_dones",      32'(done_count),      32'd1);
    checkOutput("short_frame_cnt",  32'(FRAME_CNT),       32'd2);

    $display("[TB] VSYNC during line Y=1");
    clearTallies();
    sendVsync();
    sendLine(8);
    sendLine(8);
    repeat (2) applyStimulus(1'b0, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1);
    expectLine(0, 4);
    expectLine(1, 2);
    checkPixels("verr");
    checkOutput("verr_frame_errs", 32'(frame_err_count), 32'd1);
    checkOutput("verr_line_errs",  32'(line_err_count),  32'd0);
    checkOutput("verr_dones",      32'(done_count),      32'd0);
    checkOutput("verr_frame_cnt",  32'(FRAME_CNT),       32'd2);
    clearTallies();
    nominalFrame();
    checkNominal("after_verr", 3);

    $display("[TB] reset mid-line at Y=1");
    clearTallies();
    sendVsync();
    sendLine(8);
    sendLine(8);
    repeat (2) applyStimulus(1'b0, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_pre_active", 32'(ACTIVE), 32'd1);
    checkOutput("midrst_pre_y",      32'(Y),      32'd1);
    #1;
    RSTn = 1'b0;
    #1;
    checkAllZero("midrst");
    @(posedge CLK);
    #3;
    RSTn     = 1'b1;
    prev_cnt = 8'd0;
    clearTallies();
    repeat (4) sendLine(8);
    checkOutput("midrst_idle_active", 32'(act_count), 32'd0);
    clearTallies();
    nominalFrame();
    checkNominal("midrst_nom", 1);

    $display("[TB] 257 frames, counter wrap");
    doReset();
    clearTallies();
    repeat (257) nominalFrame();
    checkOutput("wrap_dones",      32'(done_count),      32'd257);
    checkOutput("wrap_seen",       32'(wrap_seen),       32'd1);
    checkOutput("wrap_cnt_step",   32'(cnt_step_bad),    32'd0);
    checkOutput("wrap_frame_errs", 32'(frame_err_count), 32'd0);
    checkOutput("wrap_frame_cnt",  32'(FRAME_CNT),       32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sync_window_counter.md
# sync_window_counter

Frame/line/pixel coordinate generator for the OV7620 capture path. It consumes the pipeline-aligned HSYNC/VSYNC pair from the sync delay stage and derives the active capture window from it. Downstream frame-buffer write logic uses its outputs: X/Y coordinates, an active-window strobe, frame start/done pulses and framing error flags.

## Interface
- H_BACK, 2: CLK cycles from HSYNC rising edge to first active pixel of a line
- H_ACTIVE, 640: active pixels per line
- V_BACK, 1: lines (HSYNC rising edges) after VSYNC rising edge before first active line
- V_ACTIVE, 480: active lines per frame
- CLK  in  1  pixel clock, rising edge
- RSTn  in  1  reset; asynchronous, active-low
- HSYNC  in  1  line sync, active-low, idles high
- VSYNC  in  1  frame sync, active-low, idles high
- X  out  11  column of current active pixel, 0..H_ACTIVE-1
- Y  out  10  row of current active pixel, 0..V_ACTIVE-1
- ACTIVE  out  1  X/Y valid, pixel inside window
- FRAME_START  out  1  1-cycle pulse with pixel X=0,Y=0
- FRAME_DONE  out  1  1-cycle pulse with pixel X=H_ACTIVE-1,Y=V_ACTIVE-1
- LINE_ERR  out  1  1-cycle pulse, active line ended short
- FRAME_ERR  out  1  1-cycle pulse, VSYNC arrived before frame complete
- FRAME_CNT  out  8  completed-frame count, wraps 255->0

## Operation
- Reset: rH, rV (one-cycle sync history) = 1; hcnt, vcnt = 0; state WAIT_V; all outputs 0.
- Edge detect: hedge = HSYNC & ~rH; vedge = VSYNC & ~rV. Pulse bits are rising edges only.
- hcnt (12b): hedge or vedge -> 0; else +1, saturating at 4095.
- vcnt (11b): vedge -> 0 (vedge takes priority over simultaneous hedge); hedge -> +1, saturating at 2047.
- Window: inwin = (state==LINES) & hcnt in [H_BACK, H_BACK+H_ACTIVE-1] & vcnt in [V_BACK+1, V_BACK+V_ACTIVE].
- Coordinates: X = hcnt-H_BACK, Y = vcnt-V_BACK-1. Both are registered with ACTIVE and are 0 when ACTIVE=0.
- FSM:
  - WAIT_V: no outputs; vedge -> BLANK.
  - BLANK: hedge making vcnt==V_BACK+1 -> LINES.
  - LINES: on the last window pixel -> DONE. vedge -> BLANK with FRAME_ERR.
  - DONE: vedge -> BLANK, no error.
  - Any state other than WAIT_V: vedge -> BLANK.
- LINE_ERR: in LINES, hedge while hcnt < H_BACK+H_ACTIVE-1. The line just ended without reaching its last pixel. Not raised for the hedge that enters LINES. The FSM stays in LINES and the next line proceeds normally.
- A short final line means DONE is never reached; the following vedge gives FRAME_ERR.
- FRAME_START: registered with ACTIVE when X=0,Y=0.
- FRAME_DONE: registered with ACTIVE on the last pixel. FRAME_CNT increments in the same cycle FRAME_DONE asserts.
- FRAME_CNT does not change on FRAME_ERR.
- Reset mid-frame: everything returns to reset values immediately. The block waits in WAIT_V for a fresh VSYNC rising edge.

## Timing
- Edge E0 = the CLK edge that samples HSYNC=1 with rH=0. After E0, hcnt=0.
- ACTIVE rises after edge E0+H_BACK+1 and stays high for exactly H_ACTIVE cycles, with X = 0,1,…,H_ACTIVE-1.
- Fixed latency: input sync edge to window-relative outputs is 1 cycle beyond hcnt.
- LINE_ERR and FRAME_ERR assert 1 cycle after the offending edge is sampled; width 1 cycle.
- VSYNC rising edge: the first active line is the one after the (V_BACK+1)th hedge following vedge.
- Simultaneous hedge+vedge: treated as vedge only. That hedge is not counted.
- No output is combinational from inputs.

## Test plan
- Nominal frame (H_BACK=2, H_ACTIVE=4, V_BACK=1, V_ACTIVE=3, 10-cycle lines, 2-cycle sync pulses) -> 12 ACTIVE cycles; X 0..3 per line; Y 0..2; one FRAME_START, one FRAME_DONE at X=3,Y=2; FRAME_CNT 0->1.
- HSYNC toggling after reset with VSYNC held high -> ACTIVE, FRAME_START and errors remain 0 indefinitely.
- Active line Y=1 cut short (hedge at hcnt=4) -> LINE_ERR 1 cycle. Next line still produces X 0..3 with Y=2.
- VSYNC rising during line Y=1 -> FRAME_ERR 1 cycle; FRAME_CNT unchanged. The next nominal frame gives FRAME_CNT +1.
- RSTn low mid-line at Y=1 -> all outputs 0 at once. After release, no ACTIVE until a VSYNC edge; then a nominal frame.
- 257 nominal frames -> FRAME_CNT sequence ends 255->0->1; FRAME_DONE count 257.
